systolic_feeder: RTL and testbench

- Operand staging and skew stage that sits directly upstream of the PE grid in an N×N systolic matmul array.
- Accepts matrices A and B element-by-element over a valid/ready stream, buffers them, and clears the grid accumulators.
- Drives the west edge (A rows) and north edge (B columns) with diagonally skewed operands, then flags when the grid's c_out values are final.

---
 rtl/systolic_feeder.sv | 97 +++++++++
 tb/tb_systolic_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A and B from a valid/ready stream and drives a
// cleared N x N PE grid with diagonally skewed, zero-padded edge operands.
module systolic_feeder #(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   a_edge,
    output logic [N*WIDTH-1:0]   b_edge,
    output logic                 arr_clr,
    output logic                 busy,
    output logic                 done
);
    localparam int NE = 2 * N * N;
    localparam int KW = $clog2(NE);
    localparam int TW = $clog2(3 * N);
    localparam logic [KW-1:0] K_LAST = KW'(NE - 1);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef enum logic [2:0] {LOAD, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t             state;
    logic [KW-1:0]      k;
    logic [TW-1:0]      t;
    logic [TW-1:0]      nt;
    logic [WIDTH-1:0]   mem [NE];
    logic [N*WIDTH-1:0] a_nxt;
    logic [N*WIDTH-1:0] b_nxt;

    assign in_ready = state == LOAD;
    // Edges are registered, so the slot computed here is the one shown next cycle.
    assign nt = state == STREAM ? t + 1'b1 : '0;

    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(nt) >= i && int'(nt) < i + N) begin
                a_nxt[i*WIDTH +: WIDTH] = mem[KW'(i * N + int'(nt) - i)];
                b_nxt[i*WIDTH +: WIDTH] = mem[KW'(N * N + (int'(nt) - i) * N + i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) mem[k] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            k       <= '0;
            t       <= '0;
            a_edge  <= '0;
            b_edge  <= '0;
            arr_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            a_edge  <= '0;
            b_edge  <= '0;
            arr_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                LOAD: if (in_valid) begin
                    k       <= k == K_LAST ? '0 : k + 1'b1;
                    state   <= k == K_LAST ? CLEAR : LOAD;
                    arr_clr <= k == K_LAST;
                    busy    <= k == K_LAST;
                end
                CLEAR: begin
                    state  <= STREAM;
                    t      <= '0;
                    a_edge <= a_nxt;
                    b_edge <= b_nxt;
                end
                STREAM: if (t == T_LAST) begin
                    state <= DRAIN;
                end else begin
                    t      <= t + 1'b1;
                    a_edge <= a_nxt;
                    b_edge <= b_nxt;
                end
                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench driving N=2 and N=3 feeders into
// behavioural PE grids and checking edge sequences, timing and C = A x B.
module tb_systolic_feeder;
    localparam int W = 8;
    typedef logic [95:0] ev_t;
    typedef logic [8:0][31:0] cv_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] d2 = '0, d3 = '0;
    logic v2 = 1'b0, v3 = 1'b0;
    logic r2, r3, clr2, clr3, busy2, busy3, done2, done3;
    logic [2*W-1:0] a2, b2;
    logic [3*W-1:0] a3, b3;

    systolic_feeder #(.WIDTH(W), .N(2)) u2 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
        .a_edge(a2), .b_edge(b2), .arr_clr(clr2), .busy(busy2), .done(done2)
    );
    systolic_feeder #(.WIDTH(W), .N(3)) u3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
        .a_edge(a3), .b_edge(b3), .arr_clr(clr3), .busy(busy3), .done(done3)
    );

    int n_cmp = 0;
    int n_err = 0;
    int sc2 = 0, sc3 = 0;
    ev_t eq2[$], eq3[$];
    cv_t cq2[$], cq3[$];
    logic [7:0] mat [18];
    ev_t g2, g3;
    cv_t ce2, ce3;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural output-stationary grids: a moves east, b moves south, one register per PE.
    logic [31:0] c2 [2][2];
    logic [7:0]  ar2 [2][2], br2 [2][2];
    logic [31:0] c3 [3][3];
    logic [7:0]  ar3 [3][3], br3 [3][3];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
            if (clr2) begin
                c2[i][j] <= '0; ar2[i][j] <= '0; br2[i][j] <= '0;
            end else begin
                c2[i][j] <= c2[i][j]
                    + 32'(j == 0 ? a2[i*8 +: 8] : ar2[i][j == 0 ? 0 : j-1])
                    * 32'(i == 0 ? b2[j*8 +: 8] : br2[i == 0 ? 0 : i-1][j]);
                ar2[i][j] <= j == 0 ? a2[i*8 +: 8] : ar2[i][j == 0 ? 0 : j-1];
                br2[i][j] <= i == 0 ? b2[j*8 +: 8] : br2[i == 0 ? 0 : i-1][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
            if (clr3) begin
                c3[i][j] <= '0; ar3[i][j] <= '0; br3[i][j] <= '0;
            end else begin
                c3[i][j] <= c3[i][j]
                    + 32'(j == 0 ? a3[i*8 +: 8] : ar3[i][j == 0 ? 0 : j-1])
                    * 32'(i == 0 ? b3[j*8 +: 8] : br3[i == 0 ? 0 : i-1][j]);
                ar3[i][j] <= j == 0 ? a3[i*8 +: 8] : ar3[i][j == 0 ? 0 : j-1];
                br3[i][j] <= i == 0 ? b3[j*8 +: 8] : br3[i == 0 ? 0 : i-1][j];
            end
        end
    end

    always @(negedge clk) begin
        g2 = '0; g2[15:0] = a2; g2[63:48] = b2;
        if (!rst) sc2 = 0;
        if (busy2 && !clr2) begin
            sc2++;
            chk("n2_edge", g2, eq2.size() > 0 ? eq2.pop_front() : ev_t'(0));
        end else chk("n2_idle_edge", g2, 0);
        if (done2) begin
            chk("n2_window_len", sc2, 5);
            sc2 = 0;
            if (cq2.size() > 0) begin
                ce2 = cq2.pop_front();
                for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++)
                    chk("n2_c_out", c2[i][j], ce2[i*2+j]);
            end else chk("n2_spurious_done", 1, 0);
        end
    end

    always @(negedge clk) begin
        g3 = '0; g3[23:0] = a3; g3[71:48] = b3;
        if (!rst) sc3 = 0;
        if (busy3 && !clr3) begin
            sc3++;
            chk("n3_edge", g3, eq3.size() > 0 ? eq3.pop_front() : ev_t'(0));
        end else chk("n3_idle_edge", g3, 0);
        if (done3) begin
            chk("n3_window_len", sc3, 8);
            sc3 = 0;
            if (cq3.size() > 0) begin
                ce3 = cq3.pop_front();
                for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
                    chk("n3_c_out", c3[i][j], ce3[i*3+j]);
            end else chk("n3_spurious_done", 1, 0);
        end
    end

    function automatic ev_t pk(input logic [7:0] a0, a1, b0, b1);
        ev_t e;
        e = '0;
        e[15:0]  = {a1, a0};
        e[63:48] = {b1, b0};
        return e;
    endfunction

    task automatic push_basic();
        cv_t c;
        eq2.push_back(pk(1, 0, 5, 0));
        eq2.push_back(pk(2, 3, 7, 6));
        eq2.push_back(pk(0, 4, 0, 8));
        eq2.push_back(pk(0, 0, 0, 0));
        eq2.push_back(pk(0, 0, 0, 0));
        c = '0; c[0] = 19; c[1] = 22; c[2] = 43; c[3] = 50;
        cq2.push_back(c);
    endtask

    task automatic push_exp(input int n);
        ev_t e;
        cv_t c;
        for (int t = 0; t < 3*n - 2; t++) begin
            e = '0;
            for (int i = 0; i < n; i++) if (t - i >= 0 && t - i < n) begin
                e[i*8 +: 8]      = mat[i*n + t - i];
                e[48 + i*8 +: 8] = mat[n*n + (t - i)*n + i];
            end
            if (n == 2) eq2.push_back(e); else eq3.push_back(e);
        end
        if (n == 2) eq2.push_back('0); else eq3.push_back('0);
        c = '0;
        for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) for (int m = 0; m < n; m++)
            c[i*n + j] += 32'(mat[i*n + m]) * 32'(mat[n*n + m*n + j]);
        if (n == 2) cq2.push_back(c); else cq3.push_back(c);
    endtask

    task automatic drive(input int n, input logic v, input logic [7:0] d);
        if (n == 2) begin v2 = v; d2 = d; end
        else begin v3 = v; d3 = d; end
    endtask

    task automatic load(input int n, input bit bp);
        for (int k = 0; k < 2*n*n; k++) begin
            if (bp) begin
                drive(n, 1'b0, 8'hA5);
                @(posedge clk); #1;
            end
            drive(n, 1'b1, mat[k]);
            chk("load_ready", n == 2 ? r2 : r3, 1);
            @(posedge clk); #1;
        end
        drive(n, 1'b0, 8'h00);
    endtask

    // lat counts the cycle after the last accepted element as 1.
    task automatic wait_done(input int n, input bit garbage, output int lat);
        bit seen;
        seen = 0;
        lat = 1;
        for (int c = 0; c < 100; c++) begin
            if (garbage) chk("ignored_ready", n == 2 ? r2 : r3, 0);
            if (n == 2 ? done2 : done3) begin
                seen = 1;
                break;
            end
            if (garbage) drive(n, 1'b1, 8'($urandom));
            @(posedge clk); #1;
            lat++;
        end
        if (!seen) chk("done_timeout", 0, 1);
        drive(n, 1'b0, 8'h00);
        @(posedge clk); #1;
    endtask

    int lat;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(2, c[0], 8'($urandom));
            drive(3, c[0], 8'($urandom));
            @(posedge clk); #1;
            chk("rst_ready2", r2, 1);
            chk("rst_ready3", r3, 1);
            chk("rst_ctl2", {clr2, busy2, done2}, 0);
            chk("rst_ctl3", {clr3, busy3, done3}, 0);
        end
        drive(2, 1'b0, 8'h00);
        drive(3, 1'b0, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) mat[k] = 8'(k + 1);
        push_basic();
        load(2, 0);
        wait_done(2, 0, lat);
        chk("n2_latency", lat, 7);

        push_basic();
        load(2, 1);
        wait_done(2, 0, lat);
        chk("n2_bp_latency", lat, 7);

        for (int k = 0; k < 8; k++) mat[k] = 8'($urandom_range(0, 255));
        push_exp(2);
        load(2, 0);
        wait_done(2, 1, lat);
        chk("n2_ignored_latency", lat, 7);
        for (int k = 0; k < 8; k++) mat[k] = 8'(k + 1);
        push_basic();
        load(2, 0);
        wait_done(2, 0, lat);

        push_basic();
        load(2, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_state_busy", busy2, 1);
        eq2.delete();
        cq2.delete();
        rst = 1'b0;
        #1;
        chk("mid_rst_edges", {a2, b2}, 0);
        chk("mid_rst_ctl", {clr2, busy2, done2}, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mid_rst_done", done2, 0);
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("post_rst_no_done", done2, 0);
        end

        mat[0] = 1; mat[1] = 0; mat[2] = 0; mat[3] = 1;
        mat[4] = 5; mat[5] = 6; mat[6] = 7; mat[7] = 8;
        push_exp(2);
        load(2, 0);
        wait_done(2, 0, lat);
        chk("n2_ident_latency", lat, 7);

        for (int k = 0; k < 18; k++) mat[k] = k < 9 ? 8'd1 : 8'd2;
        push_exp(3);
        load(3, 0);
        wait_done(3, 0, lat);
        chk("n3_latency", lat, 10);

        repeat (4) @(posedge clk);
        #1;
        chk("n2_edges_left", eq2.size(), 0);
        chk("n2_results_left", cq2.size(), 0);
        chk("n3_edges_left", eq3.size(), 0);
        chk("n3_results_left", cq3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
